// File: rtl/disp_scan_ctrl.sv
// Display sequencing controller: captures a 9-bit adder result, converts it to BCD
// with a serial double-dabble FSM, and time-multiplexes four digits onto bcd/an.
module disp_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] res_in,
    input  logic       res_signed,
    input  logic       load,
    output logic       busy,
    output logic [3:0] bcd,
    output logic [3:0] an
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [3:0] DIG_MINUS = 4'd10;
    localparam logic [3:0] DIG_BLANK = 4'd11;
    localparam logic [3:0] LAST_ITER = 4'd8;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [8:0]    mag;
    logic [11:0]   acc;
    logic          neg_r;

    logic          pend_valid;
    logic [8:0]    pend_res;
    logic          pend_signed;

    logic [3:0]    dig [4];

    logic [CW-1:0] scan_cnt;
    logic [1:0]    idx;

    logic          start;
    logic          use_pend;
    logic [8:0]    src_res;
    logic          src_signed;
    logic          cap_neg;
    logic [8:0]    cap_mag;
    logic [11:0]   acc_adj;
    logic [11:0]   acc_next;
    logic [8:0]    mag_next;

    assign busy = (state != S_IDLE);

    // A direct load in IDLE is newer than any pending value, so it wins over it.
    always_comb begin
        start      = 1'b0;
        use_pend   = 1'b1;
        case (state)
            S_IDLE: begin
                start    = load | pend_valid;
                use_pend = ~load;
            end
            S_COMMIT: start = pend_valid;
            default:  start = 1'b0;
        endcase
        src_res    = use_pend ? pend_res    : res_in;
        src_signed = use_pend ? pend_signed : res_signed;
        cap_neg    = src_signed & src_res[8];
        cap_mag    = cap_neg ? (~src_res + 9'd1) : src_res;
    end

    always_comb begin
        acc_adj = acc;
        for (int unsigned i = 0; i < 3; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        acc_next = {acc_adj[10:0], mag[8]};
        mag_next = {mag[7:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid  <= 1'b0;
            pend_res    <= '0;
            pend_signed <= 1'b0;
        end else if (busy && load) begin
            pend_valid  <= 1'b1;
            pend_res    <= res_in;
            pend_signed <= res_signed;
        end else if (start) begin
            pend_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mag    <= '0;
            acc    <= '0;
            neg_r  <= 1'b0;
            dig[0] <= 4'd0;
            dig[1] <= DIG_BLANK;
            dig[2] <= DIG_BLANK;
            dig[3] <= DIG_BLANK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mag   <= cap_mag;
                        acc   <= '0;
                        cnt   <= '0;
                        neg_r <= cap_neg;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc <= acc_next;
                    mag <= mag_next;
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_ITER)
                        state <= S_COMMIT;
                end
                S_COMMIT: begin
                    // All four digits are written on this one edge so the scan never sees a partial result.
                    dig[0] <= acc[3:0];
                    dig[1] <= (acc[11:8] == 4'd0 && acc[7:4] == 4'd0) ? DIG_BLANK : acc[7:4];
                    dig[2] <= (acc[11:8] == 4'd0) ? DIG_BLANK : acc[11:8];
                    dig[3] <= neg_r ? DIG_MINUS : DIG_BLANK;
                    if (start) begin
                        mag   <= cap_mag;
                        acc   <= '0;
                        cnt   <= '0;
                        neg_r <= cap_neg;
                        state <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign an  = ~(4'b0001 << idx);
    assign bcd = dig[idx];

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl: reset/scan timing, a table of conversions,
// pending-overwrite and reset-abort sequences.
module tb_disp_scan_ctrl;

    typedef struct {
        logic [8:0] res;
        logic       sgn;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] res_in = '0;
    logic       res_signed = 1'b0;
    logic       load = 1'b0;
    logic       busy;
    logic [3:0] bcd;
    logic [3:0] an;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_in     (res_in),
        .res_signed (res_signed),
        .load       (load),
        .busy       (busy),
        .bcd        (bcd),
        .an         (an)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic run_load(input logic [8:0] r, input logic s);
        res_in     = r;
        res_signed = s;
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    // Samples n cycles; every bcd value must match the expected digit for the selected anode.
    task automatic scan_window(input int n, input logic [3:0] e0, input logic [3:0] e1,
                               input logic [3:0] e2, input logic [3:0] e3,
                               output int bad, output int busy_n);
        logic [3:0] e;
        bad    = 0;
        busy_n = 0;
        for (int i = 0; i < n; i++) begin
            case (an)
                4'b1110: e = e0;
                4'b1101: e = e1;
                4'b1011: e = e2;
                4'b0111: e = e3;
                default: begin e = 4'hF; bad++; end
            endcase
            if (bcd !== e) bad++;
            if (busy) busy_n++;
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       vecs [9];
        int         cnt;
        int         bad;
        int         bn;
        int         bsum;
        logic [3:0] ea;
        logic [3:0] eb;

        vecs[0] = '{9'd305,  1'b0, 4'd5, 4'd0,  4'd3,  4'd11};
        vecs[1] = '{9'h1F9,  1'b1, 4'd7, 4'd11, 4'd11, 4'd10};
        vecs[2] = '{9'h100,  1'b1, 4'd6, 4'd5,  4'd2,  4'd10};
        vecs[3] = '{9'h1FF,  1'b0, 4'd1, 4'd1,  4'd5,  4'd11};
        vecs[4] = '{9'd0,    1'b1, 4'd0, 4'd11, 4'd11, 4'd11};
        vecs[5] = '{9'h1FF,  1'b1, 4'd1, 4'd11, 4'd11, 4'd10};
        vecs[6] = '{9'h0FF,  1'b1, 4'd5, 4'd5,  4'd2,  4'd11};
        vecs[7] = '{9'd10,   1'b0, 4'd0, 4'd1,  4'd11, 4'd11};
        vecs[8] = '{9'h100,  1'b0, 4'd6, 4'd5,  4'd2,  4'd11};

        // Reset state and scan cadence
        repeat (3) step();
        check("rst_an",   int'(an),   int'(4'b1110));
        check("rst_bcd",  int'(bcd),  0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ea = ~(4'b0001 << (k / 4));
            eb = (k < 4) ? 4'd0 : 4'd11;
            check($sformatf("scan_%0d", k), int'({busy, an, bcd}), int'({1'b0, ea, eb}));
            step();
        end

        // Conversion table
        for (int v = 0; v < 9; v++) begin
            run_load(vecs[v].res, vecs[v].sgn);
            cnt = 0;
            while (busy && cnt < 40) begin
                cnt++;
                step();
            end
            check($sformatf("busy_len_%0d", v), cnt, 10);
            scan_window(16, vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3, bad, bn);
            check($sformatf("digits_%0d", v), bad, 0);
        end

        // Pending overwrite: 12, then 99 at t+3, 40 at t+5
        run_load(9'd12, 1'b0);
        bsum = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) bsum++;
            if (i == 2) begin
                res_in = 9'd99; load = 1'b1;
            end else if (i == 4) begin
                res_in = 9'd40; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
        end
        load = 1'b0;
        scan_window(10, 4'd2, 4'd1, 4'd11, 4'd11, bad, bn);
        bsum += bn;
        check("pend_first_digits", bad, 0);
        check("pend_busy_drop", int'(busy), 0);
        check("pend_busy_len", bsum, 20);
        scan_window(16, 4'd0, 4'd4, 4'd11, 4'd11, bad, bn);
        check("pend_second_digits", bad, 0);
        check("pend_idle_after", bn, 0);

        // Reset mid-conversion
        run_load(9'd305, 1'b0);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_an",   int'(an),   int'(4'b1110));
        check("abort_bcd",  int'(bcd),  0);
        step();
        rst_n = 1'b1;
        repeat (12) step();
        scan_window(16, 4'd0, 4'd11, 4'd11, 4'd11, bad, bn);
        check("abort_no_commit", bad, 0);
        check("abort_idle", bn, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
